node_info_pkt_tx: RTL and testbench



---
 rtl/node_info_pkt_tx_if.sv | 11 +
 rtl/node_info_pkt_tx.sv | 141 ++++++++++++++
 tb/tb_node_info_pkt_tx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_info_pkt_tx_if.sv
// Word stream from the node-info packet serialiser toward the radio MAC.
// The master drives data, valid and last; the slave drives ready.
interface node_info_pkt_tx_if;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/node_info_pkt_tx.sv
// Snapshots local EER-RL node state on tx_start and serialises it as a 7-word,
// 16-bit packet (header, id, dest, hops, Q, energy, XOR checksum) with a stall timeout.
module node_info_pkt_tx #(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [15:0] BCAST_ADDR  = 16'hFFFF,
    parameter int          PKT_LEN     = 7
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       tx_start,
    input  logic [15:0]                myNodeID,
    input  logic [15:0]                hopsFromSink,
    input  logic [15:0]                myQValue,
    input  logic [15:0]                energy,
    input  logic [15:0]                ch_ID,
    input  logic                       role,
    input  logic                       low_E,
    node_info_pkt_tx_if.master         tx,
    output logic                       busy,
    output logic                       tx_done,
    output logic                       tx_abort
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE, ABORT} state_e;

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] stall_q, stall_d;
    logic          cap;

    logic [15:0]   id_q, hops_q, qv_q, en_q, ch_q;
    logic          role_q, lowe_q;

    logic [3:0]    pkt_type;
    logic [15:0]   w0, w2, csum;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
        end
    end

    // Snapshot is taken only on the accepting IDLE cycle so later input changes
    // cannot leak into a packet already in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            id_q   <= '0;
            hops_q <= '0;
            qv_q   <= '0;
            en_q   <= '0;
            ch_q   <= '0;
            role_q <= 1'b0;
            lowe_q <= 1'b0;
        end else if (cap) begin
            id_q   <= myNodeID;
            hops_q <= hopsFromSink;
            qv_q   <= myQValue;
            en_q   <= energy;
            ch_q   <= ch_ID;
            role_q <= role;
            lowe_q <= low_E;
        end
    end

    always_comb begin
        pkt_type = lowe_q ? 4'h3 : (role_q ? 4'h2 : 4'h1);
        w0       = {pkt_type, role_q, lowe_q, 2'b00, 8'(PKT_LEN)};
        w2       = role_q ? BCAST_ADDR : ch_q;
        csum     = w0 ^ id_q ^ w2 ^ hops_q ^ qv_q ^ en_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    cap     = 1'b1;
                    idx_d   = '0;
                    stall_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A transfer in the same cycle as the limit wins over the timeout.
                if (tx.tx_ready) begin
                    stall_d = '0;
                    if (idx_q == 3'd6) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    if (stall_q != {CW{1'b1}}) stall_d = stall_q + 1'b1;
                    if (TIMEOUT_CYC != 0 && (int'(stall_q) + 1) >= TIMEOUT_CYC) begin
                        idx_d   = '0;
                        stall_d = '0;
                        state_d = ABORT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx.tx_data = '0;
        if (state_q == SEND) begin
            case (idx_q)
                3'd0:    tx.tx_data = w0;
                3'd1:    tx.tx_data = id_q;
                3'd2:    tx.tx_data = w2;
                3'd3:    tx.tx_data = hops_q;
                3'd4:    tx.tx_data = qv_q;
                3'd5:    tx.tx_data = en_q;
                3'd6:    tx.tx_data = csum;
                default: tx.tx_data = '0;
            endcase
        end
    end

    assign tx.tx_valid = (state_q == SEND);
    assign tx.tx_last  = (state_q == SEND) && (idx_q == 3'd6);
    assign busy        = (state_q != IDLE);
    assign tx_done     = (state_q == DONE);
    assign tx_abort    = (state_q == ABORT);

endmodule

// File: tb/tb_node_info_pkt_tx.sv
// Randomised scoreboard bench for node_info_pkt_tx: stimulus pushes expected words and
// end events into queues, a negedge monitor pops and compares on every handshake.
module tb_node_info_pkt_tx;

    localparam int TO = 4;

    typedef logic [6:0][15:0] pkt_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        tx_start;
    logic [15:0] myNodeID, hopsFromSink, myQValue, energy, ch_ID;
    logic        role, low_E;
    logic        busy, tx_done, tx_abort;

    node_info_pkt_tx_if tx();

    node_info_pkt_tx #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .nrst(nrst), .tx_start(tx_start),
        .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
        .energy(energy), .ch_ID(ch_ID), .role(role), .low_E(low_E),
        .tx(tx), .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    int          ev_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          held = 0;
    int          rmode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: packet built directly from the field definitions.
    function automatic pkt_t model(input logic [15:0] id, ch, h, q, e, input logic r, l);
        pkt_t p;
        logic [3:0] t;
        if (l) t = 4'h3;
        else if (r) t = 4'h2;
        else t = 4'h1;
        p[0] = {t, r, l, 2'b00, 8'd7};
        p[1] = id;
        p[2] = r ? 16'hFFFF : ch;
        p[3] = h;
        p[4] = q;
        p[5] = e;
        p[6] = 16'h0;
        for (int i = 0; i < 6; i++) p[6] = p[6] ^ p[i];
        return p;
    endfunction

    task automatic push_words(input pkt_t p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == 6), p[i]});
    endtask

    // Monitor / scoreboard
    initial begin
        logic        prev_stall;
        logic [16:0] prev_w;
        logic        last_acc;
        int          e;
        prev_stall = 1'b0;
        prev_w     = '0;
        last_acc   = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_stall = 1'b0;
                last_acc   = 1'b0;
                acc_cnt    = 0;
                held       = 0;
            end else begin
                if (prev_stall) begin
                    if (tx.tx_valid) chk("hold_stable", 32'({tx.tx_last, tx.tx_data}), 32'(prev_w));
                    else chk("valid_drop_only_on_abort", 32'(tx_abort), 32'd1);
                end
                if (tx_done || tx_abort) begin
                    if (ev_q.size() == 0) fail("spurious_done_or_abort");
                    else begin
                        e = ev_q.pop_front();
                        chk("end_event", tx_abort ? 32'd2 : 32'd1, 32'(e));
                    end
                    chk("words_left", 32'(exp_q.size()), 32'd0);
                    if (tx_done) chk("done_after_last", 32'(last_acc), 32'd1);
                    if (tx_abort) begin
                        chk("abort_valid_low", 32'(tx.tx_valid), 32'd0);
                        chk("abort_stall_cycles", 32'(held), 32'(TO));
                    end
                end
                last_acc = 1'b0;
                if (tx.tx_valid && tx.tx_ready) begin
                    if (exp_q.size() == 0) fail("unexpected_word");
                    else chk("word", 32'({tx.tx_last, tx.tx_data}), 32'(exp_q.pop_front()));
                    acc_cnt++;
                    held     = 0;
                    last_acc = tx.tx_last;
                end else if (tx.tx_valid) begin
                    held++;
                end
                prev_stall = tx.tx_valid && !tx.tx_ready;
                prev_w     = {tx.tx_last, tx.tx_data};
                if (!busy) begin
                    acc_cnt = 0;
                    held    = 0;
                end
            end
        end
    end

    // Ready driver: 0 always, 1 toggle, 2 random (max 3 stalls in a row), 3 stall after W1
    initial begin
        int zc;
        zc = 0;
        tx.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: tx.tx_ready = ~tx.tx_ready;
                2: begin
                    tx.tx_ready = ($urandom_range(0, 2) != 0) || (zc >= 3);
                    zc = tx.tx_ready ? 0 : zc + 1;
                end
                3: tx.tx_ready = (acc_cnt < 2);
                default: tx.tx_ready = 1'b1;
            endcase
        end
    end

    task automatic scramble();
        myNodeID     = 16'($urandom);
        hopsFromSink = 16'($urandom);
        myQValue     = 16'($urandom);
        energy       = 16'($urandom);
        ch_ID        = 16'($urandom);
        role         = 1'($urandom);
        low_E        = 1'($urandom);
    endtask

    task automatic start(input logic [15:0] id, ch, h, q, e, input logic r, l);
        @(posedge clk);
        #1;
        myNodeID = id; ch_ID = ch; hopsFromSink = h; myQValue = q; energy = e;
        role = r; low_E = l;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        scramble();
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!busy) return;
            nb++;
        end
        fail("idle_timeout");
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (acc_cnt >= n) return;
        end
        fail("accept_wait_timeout");
    endtask

    task automatic rand_pkt(input int ev);
        logic [15:0] id, ch, h, q, e;
        logic r, l;
        id = 16'($urandom); ch = 16'($urandom); h = 16'($urandom);
        q = 16'($urandom); e = 16'($urandom);
        r = 1'($urandom); l = 1'($urandom);
        push_words(model(id, ch, h, q, e, r, l), (ev == 2) ? 2 : 7);
        ev_q.push_back(ev);
        start(id, ch, h, q, e, r, l);
    endtask

    initial begin
        int   nb;
        pkt_t k;
        tx_start = 1'b0;
        myNodeID = '0; hopsFromSink = '0; myQValue = '0; energy = '0; ch_ID = '0;
        role = 1'b0; low_E = 1'b0;
        #23;
        chk("reset_outputs", 32'({tx.tx_valid, tx.tx_last, tx.tx_data, busy, tx_done, tx_abort}), 32'd0);
        #4 nrst = 1'b1;

        // Member packet, ready held high
        k = {16'h8238, 16'h8000, 16'h1234, 16'h0002, 16'h0005, 16'h000C, 16'h1007};
        push_words(k, 7); ev_q.push_back(1);
        start(16'h000C, 16'h0005, 16'h0002, 16'h1234, 16'h8000, 1'b0, 1'b0);
        wait_idle(nb);
        chk("member_busy_cycles", 32'(nb), 32'd8);

        // Cluster-head packet
        k = {16'h45C2, 16'h8000, 16'h1234, 16'h0002, 16'hFFFF, 16'h000C, 16'h2807};
        push_words(k, 7); ev_q.push_back(1);
        start(16'h000C, 16'h0005, 16'h0002, 16'h1234, 16'h8000, 1'b1, 1'b0);
        wait_idle(nb);
        chk("ch_busy_cycles", 32'(nb), 32'd8);

        // Low energy wins over role
        k = {16'h51C2, 16'h8000, 16'h1234, 16'h0002, 16'hFFFF, 16'h000C, 16'h3C07};
        push_words(k, 7); ev_q.push_back(1);
        start(16'h000C, 16'h0005, 16'h0002, 16'h1234, 16'h8000, 1'b1, 1'b1);
        wait_idle(nb);

        // Backpressure toggling, inputs scrambled after capture, tx_start in SEND ignored
        rmode = 1;
        rand_pkt(1);
        wait_acc(2);
        @(posedge clk); #1 tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
        wait_idle(nb);
        repeat (3) @(negedge clk);
        chk("no_queued_start", 32'(busy), 32'd0);

        // Timeout after W1, then a full packet
        rmode = 3;
        rand_pkt(2);
        wait_idle(nb);
        rmode = 0;
        rand_pkt(1);
        wait_idle(nb);
        chk("after_abort_busy_cycles", 32'(nb), 32'd8);

        // Reset during W3
        rand_pkt(1);
        wait_acc(3);
        #2 nrst = 1'b0;
        exp_q.delete();
        ev_q.delete();
        #1;
        chk("async_reset_outputs", 32'({tx.tx_valid, tx.tx_last, tx.tx_data, busy, tx_done, tx_abort}), 32'd0);
        @(negedge clk); @(negedge clk);
        #2 nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // Random traffic with random backpressure
        rmode = 2;
        for (int i = 0; i < 20; i++) begin
            rand_pkt(1);
            wait_idle(nb);
        end
        rmode = 0;
        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(exp_q.size() + ev_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
